iob_spi_fl_prefetch: RTL and testbench
======================================

# iob_spi_fl_prefetch

Line prefetch buffer between the instruction/data cache's native read port and the SPI flash controller's valid/address/ready request port. It converts single-word cache reads into a critical-word-first, wrap-around line fill of sequential 32-bit flash reads. Hits are served from a local line buffer without touching the SPI bus. Software-initiated flash commands bypass this block via the existing register path; `inval` discards buffered data after any flash program or erase.

## Interface
- `ADDR_W`, 24: flash byte address width.
- `DATA_W`, 32: word width; fixed at 32.
- `LINE_W`, 2: log2 of words per line (default 4 words, 16 bytes).
- `clk` in 1: system clock; all logic on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `inval` in 1: one-cycle pulse; clears all word-valid bits.
- `valid_cache` in 1: cache read request; held high until `ready_cache`.
- `address_cache` in ADDR_W: byte address; bits [1:0] ignored.
- `rdata_cache` out DATA_W: read data; valid only while `ready_cache`=1.
- `ready_cache` out 1: one-cycle completion pulse.
- `fl_valid` out 1: one-cycle pulse that starts one 32-bit flash read.
- `fl_address` out ADDR_W: word-aligned byte address; stable from the `fl_valid` cycle until `fl_ready`.
- `fl_rdata` in DATA_W: controller read data; sampled only when `fl_ready`=1.
- `fl_ready` in 1: one-cycle done pulse from the controller.

## Operation
- Storage: one line of 2^LINE_W words, a tag (address[ADDR_W-1:LINE_W+2]) and one valid bit per word.
- Decode: index = address_cache[LINE_W+1:2]. Hit = tag match and valid[index].
- FSM states:
  - IDLE -> ISSUE on a miss.
  - ISSUE: drive `fl_valid` for one cycle, then go to WAIT.
  - WAIT: on `fl_ready`, write the word, set its valid bit and advance the fill pointer modulo 2^LINE_W. Go to ISSUE if the line is not complete and no redirect is pending, otherwise go to IDLE.
- Miss start:
  - Load the tag and clear all valid bits.
  - Set the fill pointer to index, so the requested word is fetched first. The fill order wraps within the line, e.g. 2,3,0,1.
- Hit, in any state: `ready_cache` pulses the cycle after `valid_cache` is first seen high. Data comes from the buffer.
- Request for a word of the line currently filling but not yet fetched: stall. `ready_cache` pulses in the cycle after the `fl_ready` that delivers that word. Data is forwarded from the registered fill word.
- Request to a different line during a fill:
  - The in-flight SPI read is never aborted.
  - When its `fl_ready` arrives, the word is written, the fill ends, and a new miss starts on the next cycle from the pending request.
- `inval`:
  - Clears the valid bits immediately.
  - If a fill is in flight, its returning word is discarded and the fill terminates at `fl_ready`.
  - A pending cache request is then re-serviced as a miss.
- Only one request is outstanding on each side.

## Timing
- Reset values: `ready_cache`=0, `rdata_cache`=0, `fl_valid`=0, `fl_address`=0. FSM=IDLE, all valid bits=0, tag=0.
- Asserting `rst_n` mid-fill returns the block to IDLE immediately. After release, the controller's in-flight `fl_ready` is ignored because the FSM is not in WAIT.
- Hit latency: 1 cycle.
- Miss latency: 1 (decode) + 1 (ISSUE) + controller time + 1 cycle after `fl_ready`.
- Back-to-back fills: `fl_valid` for word n+1 is issued 1 cycle after `fl_ready` of word n.
- `ready_cache` never asserts twice for one request. It never asserts in the same cycle as a new `valid_cache` rising edge for a different address.
- Address arithmetic: `fl_address` = {tag, fill pointer, 2'b00}. The pointer wraps within the line; it never carries into the tag.

## Test plan
- Cold miss at 0x000108 with flash word k = 0xA5000000+k:
  - `fl_address` sequence is 0x108, 0x10C, 0x100, 0x104.
  - `ready_cache` follows the first `fl_ready` by 1 cycle with 0xA5000042.
- Hit after fill: read 0x000100 -> `ready_cache` 1 cycle later with 0xA5000040 and no `fl_valid`.
- Stall within line: request 0x00010C while only 0x108 is filled -> response 1 cycle after the second `fl_ready`, data 0xA5000043.
- Redirect: request 0x000200 during the fill of 0x100 -> current read completes, then `fl_address`=0x200 and the old line is not completed.
- `inval` mid-fill, then reread of 0x108 -> new fill starts at 0x108 and returns fresh flash data (bench changes the flash model to 0x5A000042).
- `rst_n` low during WAIT -> all outputs 0 within the reset cycle; a late `fl_ready` pulse after release causes no `ready_cache`.

Source files
------------

// File: rtl/iob_spi_fl_prefetch.sv
// rtl/iob_spi_fl_prefetch.sv - single-line critical-word-first prefetch buffer in front of the SPI flash reader
//
// Purpose: turns single-word cache reads into wrap-around line fills of 32-bit
// flash reads and serves later hits from a local line buffer.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   inval               one-cycle pulse, drops all buffered words
//   valid_cache         cache read request, held until ready_cache
//   address_cache       request byte address (bits [1:0] ignored)
//   rdata_cache         read data, valid while ready_cache=1
//   ready_cache         one-cycle completion pulse
//   fl_valid            one-cycle pulse starting one flash word read
//   fl_address          word-aligned flash byte address, held until fl_ready
//   fl_rdata, fl_ready  flash read data and its one-cycle done pulse

module iob_spi_fl_prefetch #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32,
  parameter int LINE_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inval,
  input  logic              valid_cache,
  input  logic [ADDR_W-1:0] address_cache,
  output logic [DATA_W-1:0] rdata_cache,
  output logic              ready_cache,
  output logic              fl_valid,
  output logic [ADDR_W-1:0] fl_address,
  input  logic [DATA_W-1:0] fl_rdata,
  input  logic              fl_ready
);

  localparam int WORDS = 1 << LINE_W;
  localparam int TAG_W = ADDR_W - LINE_W - 2;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t            state_q, state_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [WORDS-1:0]  vld_q, vld_d;
  logic [LINE_W-1:0] ptr_q, ptr_d;
  logic              discard_q, discard_d;
  logic [DATA_W-1:0] line_q [WORDS];
  logic [DATA_W-1:0] line_d [WORDS];
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              fl_valid_q, fl_valid_d;
  logic [ADDR_W-1:0] fl_address_q, fl_address_d;

  logic [TAG_W-1:0]  req_tag;
  logic [LINE_W-1:0] req_idx;
  logic [LINE_W-1:0] ptr_nxt;
  logic [WORDS-1:0]  vld_fill;
  logic              req;
  logic              tag_match;
  logic              hit;
  logic              busy;
  logic              word_ok;
  logic              line_full;
  logic              unused_addr_lsb;

  assign req_tag         = address_cache[ADDR_W-1:LINE_W+2];
  assign req_idx         = address_cache[LINE_W+1:2];
  assign unused_addr_lsb = ^address_cache[1:0];

  // While ready is out the cache is still holding the request it just
  // completed; ignoring valid_cache for that cycle keeps the pulse single.
  assign req       = valid_cache && !ready_q;
  assign tag_match = (req_tag == tag_q);
  assign hit       = req && tag_match && vld_q[req_idx] && !inval;
  assign busy      = (state_q != S_IDLE);

  // A returning word is kept only if no inval hit the fill while it was in flight.
  assign word_ok   = fl_ready && (state_q == S_WAIT) && !discard_q && !inval;
  assign ptr_nxt   = ptr_q + 1'b1;
  assign vld_fill  = vld_q | ({{(WORDS-1){1'b0}}, 1'b1} << ptr_q);
  assign line_full = &vld_fill;

  always_comb begin
    state_d      = state_q;
    tag_d        = tag_q;
    vld_d        = vld_q;
    ptr_d        = ptr_q;
    discard_d    = discard_q;
    line_d       = line_q;
    ready_d      = 1'b0;
    rdata_d      = rdata_q;
    fl_valid_d   = 1'b0;
    fl_address_d = fl_address_q;

    if (inval) begin
      vld_d = '0;
      if (busy) discard_d = 1'b1;
    end

    if (hit) begin
      ready_d = 1'b1;
      rdata_d = line_q[req_idx];
    end

    unique case (state_q)
      S_IDLE: begin
        if (req && !hit) begin
          // Miss: restart the line at the requested word so it returns first.
          state_d      = S_ISSUE;
          tag_d        = req_tag;
          vld_d        = '0;
          ptr_d        = req_idx;
          fl_valid_d   = 1'b1;
          fl_address_d = {req_tag, req_idx, 2'b00};
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (fl_ready) begin
          ptr_d = ptr_nxt;
          if (word_ok) begin
            line_d[ptr_q] = fl_rdata;
            vld_d[ptr_q]  = 1'b1;
            // A stalled request for exactly this word is answered straight
            // from the incoming data.
            if (req && tag_match && (req_idx == ptr_q)) begin
              ready_d = 1'b1;
              rdata_d = fl_rdata;
            end
          end
          // Stop on a complete line, a discarded word, or a request waiting
          // for another line; the waiting request then misses from IDLE.
          if (!word_ok || line_full || (req && !tag_match)) begin
            state_d   = S_IDLE;
            discard_d = 1'b0;
          end else begin
            state_d      = S_ISSUE;
            fl_valid_d   = 1'b1;
            fl_address_d = {tag_q, ptr_nxt, 2'b00};
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      tag_q        <= '0;
      vld_q        <= '0;
      ptr_q        <= '0;
      discard_q    <= 1'b0;
      for (int i = 0; i < WORDS; i++) line_q[i] <= '0;
      ready_q      <= 1'b0;
      rdata_q      <= '0;
      fl_valid_q   <= 1'b0;
      fl_address_q <= '0;
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      vld_q        <= vld_d;
      ptr_q        <= ptr_d;
      discard_q    <= discard_d;
      line_q       <= line_d;
      ready_q      <= ready_d;
      rdata_q      <= rdata_d;
      fl_valid_q   <= fl_valid_d;
      fl_address_q <= fl_address_d;
    end
  end

  assign ready_cache = ready_q;
  assign rdata_cache = rdata_q;
  assign fl_valid    = fl_valid_q;
  assign fl_address  = fl_address_q;

endmodule

// File: tb/tb_iob_spi_fl_prefetch.sv
// tb/tb_iob_spi_fl_prefetch.sv - self-checking bench for iob_spi_fl_prefetch
module tb_iob_spi_fl_prefetch;

  localparam int AW = 24;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          inval = 1'b0;
  logic          valid_cache = 1'b0;
  logic [AW-1:0] address_cache = '0;
  logic [DW-1:0] rdata_cache;
  logic          ready_cache;
  logic          fl_valid;
  logic [AW-1:0] fl_address;
  logic [DW-1:0] fl_rdata = '0;
  logic          fl_ready = 1'b0;

  iob_spi_fl_prefetch #(.ADDR_W(AW), .DATA_W(DW), .LINE_W(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .inval         (inval),
    .valid_cache   (valid_cache),
    .address_cache (address_cache),
    .rdata_cache   (rdata_cache),
    .ready_cache   (ready_cache),
    .fl_valid      (fl_valid),
    .fl_address    (fl_address),
    .fl_rdata      (fl_rdata),
    .fl_ready      (fl_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    int            lat;
    logic [31:0]   data;
    int            exp_lat;
    int            exp_nfl;
  } vec_t;

  vec_t          tv[6];
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  logic [31:0]   fl_base = 32'hA500_0000;
  int            lat_cfg = 2;
  int            cnt = 0;
  logic [AW-1:0] pend_addr = '0;
  logic [31:0]   pend_data = '0;
  logic [AW-1:0] fl_log[$];
  int            flr_cyc[int];
  int            nfl = 0;
  bit            res[int];
  int            cur_line = -1;
  bit            ign = 1'b0;

  // Flash word k holds base + k, k being the word number of the byte address.
  function automatic logic [31:0] fword(input logic [31:0] base, input logic [AW-1:0] a);
    return base + 32'(a >> 2);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: sample just after the edge, then run the flash controller model.
  // The model latches read data when the read is issued, so a read in flight
  // across a flash program still returns the old contents.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (fl_ready) fl_ready = 1'b0;
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        fl_ready = 1'b1;
        fl_rdata = pend_data;
        flr_cyc[int'(pend_addr)] = cyc;
        if (ign) ign = 1'b0;
        else     res[int'(pend_addr)] = 1'b1;
      end
    end
    if (fl_valid) begin
      fl_log.push_back(fl_address);
      nfl++;
      if (int'(fl_address >> 4) != cur_line) begin
        res.delete();
        cur_line = int'(fl_address >> 4);
      end
      pend_addr = fl_address;
      pend_data = fword(fl_base, fl_address);
      cnt       = lat_cfg;
    end
  endtask

  task automatic do_inval();
    inval = 1'b1;
    if (cnt > 0) ign = 1'b1;
    res.delete();
    step();
    inval = 1'b0;
  endtask

  // Cache-side read: valid held through the ready cycle, as a real cache does.
  task automatic request(input logic [AW-1:0] a, output int lat, output logic [31:0] d,
                         output int rc);
    bit got;
    got = 1'b0;
    lat = 0;
    d   = '0;
    rc  = 0;
    address_cache = a;
    valid_cache   = 1'b1;
    for (int i = 1; i <= 60 && !got; i++) begin
      step();
      if (ready_cache) begin
        got = 1'b1;
        lat = i;
        d   = rdata_cache;
        rc  = cyc;
      end
    end
    check("req_done", got, 1);
    step();
    check("single_pulse", ready_cache, 0);
    valid_cache = 1'b0;
  endtask

  initial begin
    int            lat_o;
    logic [31:0]   dat_o;
    int            rc_o;
    int            base_idx;
    int            n0;
    int            n_rdy;
    bit            was_res;
    logic [AW-1:0] a;
    logic [31:0]   expd;
    logic [AW-1:0] cold_ord[4];
    logic [AW-1:0] redir_ord[6];

    tv[0] = '{24'h108, 2, 32'hA500_0042, 4, 4};
    tv[1] = '{24'h100, 2, 32'hA500_0040, 1, 0};
    tv[2] = '{24'h10C, 2, 32'hA500_0043, 1, 0};
    tv[3] = '{24'h104, 2, 32'hA500_0041, 1, 0};
    tv[4] = '{24'h200, 1, 32'hA500_0080, 3, 4};
    tv[5] = '{24'h20C, 1, 32'hA500_0083, 1, 0};
    cold_ord  = '{24'h108, 24'h10C, 24'h100, 24'h104};
    redir_ord = '{24'h100, 24'h104, 24'h200, 24'h204, 24'h208, 24'h20C};

    rst_n = 1'b0;
    step();
    step();
    check("rst_ready", ready_cache, 0);
    check("rst_rdata", rdata_cache, 0);
    check("rst_fl_valid", fl_valid, 0);
    check("rst_fl_address", fl_address, 0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++) begin
      lat_cfg = tv[i].lat;
      n0 = nfl;
      request(tv[i].addr, lat_o, dat_o, rc_o);
      check($sformatf("vec%0d_data", i), dat_o, tv[i].data);
      check($sformatf("vec%0d_lat", i), lat_o, tv[i].exp_lat);
      if (tv[i].exp_nfl > 0)
        check($sformatf("vec%0d_after_flready", i), rc_o, flr_cyc[int'(tv[i].addr)] + 1);
      repeat (16) step();
      check($sformatf("vec%0d_nfl", i), nfl - n0, tv[i].exp_nfl);
    end
    for (int i = 0; i < 4; i++)
      check($sformatf("cold_order%0d", i), fl_log[i], cold_ord[i]);

    // Stall on a word of the filling line that has not arrived yet.
    do_inval();
    lat_cfg = 3;
    request(24'h108, lat_o, dat_o, rc_o);
    check("stall_first", dat_o, 32'hA500_0042);
    request(24'h10C, lat_o, dat_o, rc_o);
    check("stall_data", dat_o, 32'hA500_0043);
    check("stall_timing", rc_o, flr_cyc[32'h10C] + 1);
    repeat (16) step();

    // Redirect to another line while the 0x100 line is filling.
    do_inval();
    lat_cfg = 3;
    base_idx = fl_log.size();
    request(24'h100, lat_o, dat_o, rc_o);
    request(24'h200, lat_o, dat_o, rc_o);
    check("redirect_data", dat_o, 32'hA500_0080);
    repeat (20) step();
    check("redirect_log_len", fl_log.size() - base_idx, 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("redirect_order%0d", i), fl_log[base_idx + i], redir_ord[i]);

    // Flash reprogrammed while a fill is in flight, then reread.
    do_inval();
    lat_cfg = 3;
    request(24'h108, lat_o, dat_o, rc_o);
    check("inval_pre_data", dat_o, 32'hA500_0042);
    fl_base = 32'h5A00_0000;
    do_inval();
    base_idx = fl_log.size();
    request(24'h108, lat_o, dat_o, rc_o);
    check("inval_refill_addr", fl_log[base_idx], 24'h108);
    check("inval_fresh_data", dat_o, 32'h5A00_0042);
    repeat (16) step();
    request(24'h10C, lat_o, dat_o, rc_o);
    check("inval_discard_data", dat_o, 32'h5A00_0043);

    // Reset while waiting for flash data; the stray fl_ready arrives afterwards.
    repeat (4) step();
    do_inval();
    lat_cfg = 6;
    address_cache = 24'h100;
    valid_cache   = 1'b1;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    check("midrst_ready", ready_cache, 0);
    check("midrst_rdata", rdata_cache, 0);
    check("midrst_fl_valid", fl_valid, 0);
    check("midrst_fl_address", fl_address, 0);
    valid_cache = 1'b0;
    if (cnt > 0) ign = 1'b1;
    res.delete();
    cur_line = -1;
    step();
    rst_n = 1'b1;
    n_rdy = 0;
    repeat (10) begin
      step();
      if (ready_cache) n_rdy++;
    end
    check("late_fl_ready", n_rdy, 0);
    lat_cfg = 2;
    request(24'h104, lat_o, dat_o, rc_o);
    check("post_reset_data", dat_o, fword(fl_base, 24'h104));
    check("post_reset_lat", lat_o, 4);

    // Random reads over three lines with occasional reprogram + inval.
    repeat (16) step();
    do_inval();
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        fl_base = $urandom() & 32'hFF00_0000;
        do_inval();
      end
      lat_cfg = $urandom_range(1, 4);
      a       = AW'(32'h100 * $urandom_range(1, 3) + 32'd4 * $urandom_range(0, 3));
      expd    = fword(fl_base, a);
      was_res = res.exists(int'(a));
      request(a, lat_o, dat_o, rc_o);
      check($sformatf("rnd%0d_data@%0h", n, a), dat_o, expd);
      if (was_res) check($sformatf("rnd%0d_hit_lat", n), lat_o, 1);
      else         check($sformatf("rnd%0d_miss_lat", n), lat_o > 1, 1);
      repeat ($urandom_range(0, 3)) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
